// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 machine-mode trap controller: FSM states,
// cause codes, PC-source selects and SYSTEM-instruction funct12 values.
package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } state_t;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] CAUSE_INT_SOFTWARE     = 4'd3;
    localparam logic [3:0] CAUSE_INT_TIMER        = 4'd7;
    localparam logic [3:0] CAUSE_INT_EXTERNAL     = 4'd11;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    localparam logic [4:0]  OPC_SYSTEM = 5'b11100;
    localparam logic [2:0]  F3_PRIV    = 3'b000;
    localparam logic [11:0] F12_ECALL  = 12'h000;
    localparam logic [11:0] F12_EBREAK = 12'h001;
    localparam logic [11:0] F12_MRET   = 12'h302;
    localparam logic [11:0] F12_WFI    = 12'h105;

    // Causes that also carry a faulting address into mtval.
    function automatic logic is_misaligned_cause(input logic [3:0] cause);
        return (cause == CAUSE_INSTR_MISALIGNED) ||
               (cause == CAUSE_LOAD_MISALIGNED)  ||
               (cause == CAUSE_STORE_MISALIGNED);
    endfunction

endpackage

// File: rtl/msrv32_trap_priority.sv
// Combinational trap arbiter: exceptions by fixed priority, then interrupts.
// Interrupt logic exists only when MSRV32_INTERRUPTS_EN is defined.
module msrv32_trap_priority
    import msrv32_pkg::*;
(
    input  logic       i_instr_misaligned,
    input  logic       i_illegal,
    input  logic       i_ebreak,
    input  logic       i_ecall,
    input  logic       i_store_misaligned,
    input  logic       i_load_misaligned,
    input  logic       i_mie,
    input  logic       i_meie,
    input  logic       i_mtie,
    input  logic       i_msie,
    input  logic       i_meip,
    input  logic       i_mtip,
    input  logic       i_msip,
    output logic       o_trap,
    output logic       o_i_or_e,
    output logic [3:0] o_cause
);

    logic w_ext_irq;
    logic w_sw_irq;
    logic w_tmr_irq;

`ifdef MSRV32_INTERRUPTS_EN
    assign w_ext_irq = i_mie & i_meip & i_meie;
    assign w_sw_irq  = i_mie & i_msip & i_msie;
    assign w_tmr_irq = i_mie & i_mtip & i_mtie;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{i_mie, i_meie, i_mtie, i_msie, i_meip, i_mtip, i_msip};
    assign w_ext_irq = 1'b0;
    assign w_sw_irq  = 1'b0;
    assign w_tmr_irq = 1'b0;
`endif

    // Priority chain: any exception beats every interrupt.
    always_comb begin
        o_trap   = 1'b1;
        o_i_or_e = 1'b0;
        o_cause  = CAUSE_INSTR_MISALIGNED;
        if (i_instr_misaligned) begin
            o_cause = CAUSE_INSTR_MISALIGNED;
        end else if (i_illegal) begin
            o_cause = CAUSE_ILLEGAL_INSTR;
        end else if (i_ebreak) begin
            o_cause = CAUSE_BREAKPOINT;
        end else if (i_ecall) begin
            o_cause = CAUSE_ECALL_M;
        end else if (i_store_misaligned) begin
            o_cause = CAUSE_STORE_MISALIGNED;
        end else if (i_load_misaligned) begin
            o_cause = CAUSE_LOAD_MISALIGNED;
        end else if (w_ext_irq) begin
            o_i_or_e = 1'b1;
            o_cause  = CAUSE_INT_EXTERNAL;
        end else if (w_sw_irq) begin
            o_i_or_e = 1'b1;
            o_cause  = CAUSE_INT_SOFTWARE;
        end else if (w_tmr_irq) begin
            o_i_or_e = 1'b1;
            o_cause  = CAUSE_INT_TIMER;
        end else begin
            o_trap = 1'b0;
        end
    end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap controller FSM (RESET/OPERATING/TRAP_TAKEN/TRAP_RETURN).
// Interrupt support is built in only when MSRV32_INTERRUPTS_EN is defined.
module msrv32_machine_control
    import msrv32_pkg::*;
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        illegal_instr_in,
    input  logic        misaligned_load_in,
    input  logic        misaligned_store_in,
    input  logic        misaligned_instr_in,
    input  logic [4:0]  opcode_6_to_2_in,
    input  logic [2:0]  funct3_in,
    input  logic [11:0] funct12_in,
    input  logic        mie_in,
    input  logic        meie_in,
    input  logic        mtie_in,
    input  logic        msie_in,
    input  logic        meip_in,
    input  logic        mtip_in,
    input  logic        msip_in,
    output logic        trap_taken_out,
    output logic [1:0]  pc_src_out,
    output logic        flush_out,
    output logic        set_cause_out,
    output logic        set_epc_out,
    output logic        i_or_e_out,
    output logic [3:0]  cause_out,
    output logic        misaligned_exception_out,
    output logic        mie_clear_out,
    output logic        mie_set_out,
    output logic        instret_inc_out
);

    state_t     r_state;
    logic [1:0] r_pc_src;
    logic       r_flush;
    logic       r_set_cause;
    logic       r_set_epc;
    logic       r_mie_clear;
    logic       r_mie_set;
    logic       r_i_or_e;
    logic [3:0] r_cause;
    logic       r_misaligned;

    logic       w_system;
    logic       w_ecall;
    logic       w_ebreak;
    logic       w_mret;
    logic       w_trap_raw;
    logic       w_trap_i_or_e;
    logic [3:0] w_trap_cause;
    logic       w_operating;
    logic       w_trap;

    // WFI needs no decode: it simply retires like any other NOP.
    assign w_system = (opcode_6_to_2_in == OPC_SYSTEM) && (funct3_in == F3_PRIV);
    assign w_ecall  = w_system && (funct12_in == F12_ECALL);
    assign w_ebreak = w_system && (funct12_in == F12_EBREAK);
    assign w_mret   = w_system && (funct12_in == F12_MRET);

    msrv32_trap_priority u_trap_priority (
        .i_instr_misaligned (misaligned_instr_in),
        .i_illegal          (illegal_instr_in),
        .i_ebreak           (w_ebreak),
        .i_ecall            (w_ecall),
        .i_store_misaligned (misaligned_store_in),
        .i_load_misaligned  (misaligned_load_in),
        .i_mie              (mie_in),
        .i_meie             (meie_in),
        .i_mtie             (mtie_in),
        .i_msie             (msie_in),
        .i_meip             (meip_in),
        .i_mtip             (mtip_in),
        .i_msip             (msip_in),
        .o_trap             (w_trap_raw),
        .o_i_or_e           (w_trap_i_or_e),
        .o_cause            (w_trap_cause)
    );

    assign w_operating = (r_state == ST_OPERATING);
    assign w_trap      = w_operating & w_trap_raw;

    // State register with per-state outputs registered alongside the next state.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_state      <= ST_RESET;
            r_pc_src     <= PC_SRC_BOOT;
            r_flush      <= 1'b1;
            r_set_cause  <= 1'b0;
            r_set_epc    <= 1'b0;
            r_mie_clear  <= 1'b0;
            r_mie_set    <= 1'b0;
            r_i_or_e     <= 1'b0;
            r_cause      <= 4'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_set_cause <= 1'b0;
            r_set_epc   <= 1'b0;
            r_mie_clear <= 1'b0;
            r_mie_set   <= 1'b0;
            case (r_state)
                ST_OPERATING: begin
                    if (w_trap) begin
                        r_state      <= ST_TRAP_TAKEN;
                        r_pc_src     <= PC_SRC_TRAP;
                        r_flush      <= 1'b1;
                        r_set_cause  <= 1'b1;
                        r_set_epc    <= 1'b1;
                        r_mie_clear  <= 1'b1;
                        r_i_or_e     <= w_trap_i_or_e;
                        r_cause      <= w_trap_cause;
                        r_misaligned <= ~w_trap_i_or_e & is_misaligned_cause(w_trap_cause);
                    end else if (w_mret) begin
                        r_state  <= ST_TRAP_RETURN;
                        r_pc_src <= PC_SRC_EPC;
                        r_flush  <= 1'b1;
                        r_mie_set <= 1'b1;
                    end else begin
                        r_state  <= ST_OPERATING;
                        r_pc_src <= PC_SRC_NEXT;
                        r_flush  <= 1'b0;
                    end
                end
                ST_RESET, ST_TRAP_TAKEN, ST_TRAP_RETURN: begin
                    r_state  <= ST_OPERATING;
                    r_pc_src <= PC_SRC_NEXT;
                    r_flush  <= 1'b0;
                end
                default: begin
                    r_state  <= ST_RESET;
                    r_pc_src <= PC_SRC_BOOT;
                    r_flush  <= 1'b1;
                end
            endcase
        end
    end

    assign trap_taken_out           = w_trap;
    assign instret_inc_out          = w_operating & ~w_trap_raw;
    assign pc_src_out               = r_pc_src;
    assign flush_out                = r_flush;
    assign set_cause_out            = r_set_cause;
    assign set_epc_out              = r_set_epc;
    assign mie_clear_out            = r_mie_clear;
    assign mie_set_out              = r_mie_set;
    assign i_or_e_out               = r_i_or_e;
    assign cause_out                = r_cause;
    assign misaligned_exception_out = r_misaligned;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed + randomized bench for msrv32_machine_control against a mode-level
// reference model; honours MSRV32_INTERRUPTS_EN the same way as the design.
module tb_msrv32_machine_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        illegal, mis_load, mis_store, mis_instr;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] funct12;
    logic        mie, meie, mtie, msie, meip, mtip, msip;
    logic        trap_taken, flush, set_cause, set_epc, i_or_e, mis_exc;
    logic        mie_clear, mie_set, instret;
    logic [1:0]  pc_src;
    logic [3:0]  cause;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = boot, 1 = running, 2 = entering trap, 3 = returning.
    int         m_mode = 0;
    logic [3:0] m_cause = 4'd0;
    logic       m_ioe = 1'b0;
    logic       m_mis = 1'b0;
    logic       e_trap;
    logic       e_ioe;
    logic [3:0] e_cause;
    logic       e_mret;

    always #5 clk = ~clk;

    msrv32_machine_control dut (
        .ms_riscv32_mp_clk_in     (clk),
        .ms_riscv32_mp_rst_in     (rst_n),
        .illegal_instr_in         (illegal),
        .misaligned_load_in       (mis_load),
        .misaligned_store_in      (mis_store),
        .misaligned_instr_in      (mis_instr),
        .opcode_6_to_2_in         (opcode),
        .funct3_in                (funct3),
        .funct12_in               (funct12),
        .mie_in                   (mie),
        .meie_in                  (meie),
        .mtie_in                  (mtie),
        .msie_in                  (msie),
        .meip_in                  (meip),
        .mtip_in                  (mtip),
        .msip_in                  (msip),
        .trap_taken_out           (trap_taken),
        .pc_src_out               (pc_src),
        .flush_out                (flush),
        .set_cause_out            (set_cause),
        .set_epc_out              (set_epc),
        .i_or_e_out               (i_or_e),
        .cause_out                (cause),
        .misaligned_exception_out (mis_exc),
        .mie_clear_out            (mie_clear),
        .mie_set_out              (mie_set),
        .instret_inc_out          (instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First matching entry of an ordered priority list wins.
    task automatic ref_trap();
        logic       sys;
        logic       hit [9];
        logic [3:0] code [9];
        sys = (opcode == 5'b11100) && (funct3 == 3'b000);
        hit[0] = mis_instr;                    code[0] = 4'd0;
        hit[1] = illegal;                      code[1] = 4'd2;
        hit[2] = sys && (funct12 == 12'h001);  code[2] = 4'd3;
        hit[3] = sys && (funct12 == 12'h000);  code[3] = 4'd11;
        hit[4] = mis_store;                    code[4] = 4'd6;
        hit[5] = mis_load;                     code[5] = 4'd4;
`ifdef MSRV32_INTERRUPTS_EN
        hit[6] = mie && meip && meie;          code[6] = 4'd11;
        hit[7] = mie && msip && msie;          code[7] = 4'd3;
        hit[8] = mie && mtip && mtie;          code[8] = 4'd7;
`else
        hit[6] = 1'b0; code[6] = 4'd11;
        hit[7] = 1'b0; code[7] = 4'd3;
        hit[8] = 1'b0; code[8] = 4'd7;
`endif
        e_mret  = sys && (funct12 == 12'h302);
        e_trap  = 1'b0;
        e_ioe   = 1'b0;
        e_cause = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (!e_trap && hit[k]) begin
                e_trap  = 1'b1;
                e_ioe   = (k >= 6);
                e_cause = code[k];
            end
        end
    endtask

    task automatic check_now(input string tag);
        logic [1:0] e_pc;
        logic       run;
        ref_trap();
        run  = (m_mode == 1);
        e_pc = (m_mode == 0) ? 2'b00 : (m_mode == 2) ? 2'b10 : (m_mode == 3) ? 2'b01 : 2'b11;
        chk({tag, ".pc_src"},    {30'd0, pc_src}, {30'd0, e_pc});
        chk({tag, ".flush"},     {31'd0, flush}, {31'd0, (m_mode != 1)});
        chk({tag, ".trap"},      {31'd0, trap_taken}, {31'd0, run && e_trap});
        chk({tag, ".instret"},   {31'd0, instret}, {31'd0, run && !e_trap});
        chk({tag, ".set_cause"}, {31'd0, set_cause}, {31'd0, (m_mode == 2)});
        chk({tag, ".set_epc"},   {31'd0, set_epc}, {31'd0, (m_mode == 2)});
        chk({tag, ".mie_clear"}, {31'd0, mie_clear}, {31'd0, (m_mode == 2)});
        chk({tag, ".mie_set"},   {31'd0, mie_set}, {31'd0, (m_mode == 3)});
        chk({tag, ".cause"},     {28'd0, cause}, {28'd0, m_cause});
        chk({tag, ".i_or_e"},    {31'd0, i_or_e}, {31'd0, m_ioe});
        chk({tag, ".mis_exc"},   {31'd0, mis_exc}, {31'd0, m_mis});
    endtask

    task automatic advance();
        logic t;
        ref_trap();
        t = (m_mode == 1) && e_trap;
        @(posedge clk);
        if (!rst_n) begin
            m_mode = 0;
        end else if (m_mode == 1 && t) begin
            m_mode  = 2;
            m_cause = e_cause;
            m_ioe   = e_ioe;
            m_mis   = !e_ioe && (e_cause == 4'd0 || e_cause == 4'd4 || e_cause == 4'd6);
        end else if (m_mode == 1 && e_mret) begin
            m_mode = 3;
        end else begin
            m_mode = 1;
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        #1;
        check_now(tag);
        advance();
    endtask

    task automatic clr();
        {illegal, mis_load, mis_store, mis_instr} = 4'b0000;
        opcode = 5'b01100; funct3 = 3'b000; funct12 = 12'h000;
        {mie, meie, mtie, msie, meip, mtip, msip} = 7'b0000000;
    endtask

    task automatic sys(input logic [11:0] f12);
        opcode = 5'b11100; funct3 = 3'b000; funct12 = f12;
    endtask

    task automatic model_reset();
        m_mode = 0; m_cause = 4'd0; m_ioe = 1'b0; m_mis = 1'b0;
    endtask

    initial begin
        clr();
        repeat (2) @(negedge clk);
        #1;
        check_now("reset_held");
        rst_n = 1'b1;
        step("boot");
        step("first_run");

        illegal = 1'b1; mis_load = 1'b1;
        step("ill_load_detect");
        clr();
        step("ill_load_entry");
        step("ill_load_back");

        sys(12'h000);
        step("ecall_detect");
        clr();
        step("ecall_entry");
        sys(12'h302);
        step("mret_detect");
        clr();
        step("mret_return");
        sys(12'h105);
        step("wfi_nop");

        mie = 1'b1; meip = 1'b1; meie = 1'b1; mtip = 1'b1; mtie = 1'b1;
        step("irq_ext_tmr");
        clr();
        step("irq_entry");
        mie = 1'b0; meip = 1'b1; meie = 1'b1; mtip = 1'b1; mtie = 1'b1;
        step("irq_masked_a");
        step("irq_masked_b");

        clr();
        sys(12'h302); mie = 1'b1; mtip = 1'b1; mtie = 1'b1;
        step("mret_vs_timer");
        clr();
        step("mret_vs_timer_next");
        step("mret_vs_timer_back");

        // Randomized traffic: sparse faults, occasional SYSTEM instructions.
        for (int n = 0; n < 400; n++) begin
            illegal   = ($urandom_range(0, 9) == 0);
            mis_load  = ($urandom_range(0, 9) == 0);
            mis_store = ($urandom_range(0, 9) == 0);
            mis_instr = ($urandom_range(0, 11) == 0);
            opcode    = ($urandom_range(0, 2) == 0) ? 5'b11100 : 5'($urandom_range(0, 31));
            funct3    = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: funct12 = 12'h000;
                1: funct12 = 12'h001;
                2: funct12 = 12'h302;
                3: funct12 = 12'h105;
                default: funct12 = 12'($urandom);
            endcase
            {mie, meie, mtie, msie, meip, mtip, msip} = 7'($urandom);
            step("rand");
        end

        // Reset during trap entry must drop every strobe immediately.
        clr();
        step("pre_store");
        mis_store = 1'b1;
        step("store_detect");
        clr();
        #1;
        check_now("store_entry");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now("reset_mid_trap");
        advance();
        step("reset_hold");
        rst_n = 1'b1;
        step("reboot");
        step("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
